// File: rtl/ledr_arbiter_if.sv
// Handshake bundle between the four LED requesters and the LED bank arbiter.
// The master side holds requests and patterns; the slave side is the arbiter.
interface ledr_arbiter_if;
  logic [3:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [15:0] data3;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] ledr;

  modport master (
    output req, data0, data1, data2, data3,
    input  gnt, owner, busy, ledr
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output gnt, owner, busy, ledr
  );
endinterface

// File: rtl/ledr_arbiter.sv
// Round-robin LED bank arbiter with a minimum-hold timer for four requesters.
// Define LEDR_ARBITER_MANUAL_EN to add a man_en/man_sel override that freezes arbitration.
module ledr_arbiter #(
  parameter int          HOLD_CYCLES  = 8,
  parameter int          CNT_W        = 4,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
`ifdef LEDR_ARBITER_MANUAL_EN
  input  logic       man_en,
  input  logic [1:0] man_sel,
`endif
  ledr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ptr;
  logic [3:0]       gnt_q;
  logic [1:0]       owner_q;
  logic             busy_q;
  logic [15:0]      ledr_q;

  // First set bit of r scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (r[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [15:0] data_of(input logic [1:0] sel, input logic [15:0] d0,
                                          input logic [15:0] d1, input logic [15:0] d2,
                                          input logic [15:0] d3);
    case (sel)
      2'd0:    data_of = d0;
      2'd1:    data_of = d1;
      2'd2:    data_of = d2;
      default: data_of = d3;
    endcase
  endfunction

  logic [3:0]  others;
  logic [1:0]  idle_win;
  logic [1:0]  next_win;
  logic [1:0]  owner_next;
  logic        owner_req;
  logic [15:0] owner_data;

  assign others     = bus.req & ~gnt_q;
  assign owner_next = owner_q + 2'd1;
  assign idle_win   = rr_pick(bus.req, ptr);
  assign next_win   = rr_pick(others, owner_next);
  assign owner_req  = bus.req[owner_q];
  assign owner_data = data_of(owner_q, bus.data0, bus.data1, bus.data2, bus.data3);

  // NOTE: every register here uses <= so all state updates see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 2'd0;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
      ledr_q  <= IDLE_PATTERN;
    end
`ifdef LEDR_ARBITER_MANUAL_EN
    else if (man_en) begin
      ledr_q <= data_of(man_sel, bus.data0, bus.data1, bus.data2, bus.data3);
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state   <= GRANT;
            gnt_q   <= 4'b0001 << idle_win;
            owner_q <= idle_win;
            busy_q  <= 1'b1;
            cnt     <= '0;
          end
        end
        GRANT: begin
          ledr_q <= owner_data;
          if (!owner_req || (cnt == HOLD_LAST && |others)) begin
            ptr <= owner_next;
            cnt <= '0;
            if (|others) begin
              gnt_q   <= 4'b0001 << next_win;
              owner_q <= next_win;
            end else begin
              // Only reachable on release: the bank goes dark at the same edge.
              state  <= IDLE;
              gnt_q  <= 4'b0000;
              busy_q <= 1'b0;
              ledr_q <= IDLE_PATTERN;
            end
          end else if (cnt != HOLD_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.ledr  = ledr_q;

endmodule

// File: tb/tb_ledr_arbiter.sv
// Directed self-checking bench for ledr_arbiter, built with HOLD_CYCLES=4.
module tb_ledr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  logic [15:0] d [4] = '{16'h1111, 16'h2222, 16'hA5A5, 16'h3333};

  ledr_arbiter_if bus ();

`ifdef LEDR_ARBITER_MANUAL_EN
  logic       man_en  = 1'b0;
  logic [1:0] man_sel = 2'd0;
`endif

  ledr_arbiter #(.HOLD_CYCLES(4), .CNT_W(4), .IDLE_PATTERN(16'h0000)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef LEDR_ARBITER_MANUAL_EN
    .man_en (man_en),
    .man_sel(man_sel),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_data();
    bus.data0 = d[0];
    bus.data1 = d[1];
    bus.data2 = d[2];
    bus.data3 = d[3];
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 4'b1111;
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.gnt, bus.busy, bus.owner, bus.ledr} !== {4'b0000, 1'b0, 2'd0, 16'h0000}) begin
      failed++;
      $display("FAIL reset_state gnt=%b busy=%b owner=%0d ledr=%h expected 0000/0/0/0000",
               bus.gnt, bus.busy, bus.owner, bus.ledr);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({bus.gnt, bus.busy, bus.owner, bus.ledr} !== {4'b0001, 1'b1, 2'd0, 16'h0000}) begin
      failed++;
      $display("FAIL reset_first_grant gnt=%b busy=%b owner=%0d ledr=%h expected 0001/1/0/0000",
               bus.gnt, bus.busy, bus.owner, bus.ledr);
    end
    tick();
    tests++;
    if (bus.ledr !== 16'h1111) begin
      failed++;
      $display("FAIL reset_first_data ledr=%h expected 1111", bus.ledr);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100;
    for (int i = 1; i <= 20; i++) begin
      logic [15:0] exp_l;
      tick();
      exp_l = (i == 1) ? 16'h0000 : 16'hA5A5;
      tests++;
      if (bus.gnt !== 4'b0100 || bus.ledr !== exp_l) begin
        failed++;
        $display("FAIL single_hold cycle %0d gnt=%b ledr=%h expected 0100/%h",
                 i, bus.gnt, bus.ledr, exp_l);
      end
    end
    bus.req = 4'b0000;
    tick();
    tests++;
    if ({bus.gnt, bus.busy, bus.ledr} !== {4'b0000, 1'b0, 16'h0000}) begin
      failed++;
      $display("FAIL single_release gnt=%b busy=%b ledr=%h expected 0000/0/0000",
               bus.gnt, bus.busy, bus.ledr);
    end
  endtask

  task automatic test_rotation();
    int seq [3] = '{0, 1, 3};
    int prev = 0;
    do_reset();
    bus.req = 4'b1011;
    for (int i = 0; i < 24; i++) begin
      int          e;
      logic [15:0] exp_l;
      tick();
      e     = seq[(i / 4) % 3];
      exp_l = (i == 0) ? 16'h0000 : d[prev];
      tests++;
      if (bus.gnt !== 4'(1 << e) || bus.owner !== 2'(e) || bus.busy !== 1'b1 ||
          bus.ledr !== exp_l) begin
        failed++;
        $display("FAIL rotation cycle %0d gnt=%b owner=%0d busy=%b ledr=%h expected %b/%0d/1/%h",
                 i, bus.gnt, bus.owner, bus.busy, bus.ledr, 4'(1 << e), e, exp_l);
      end
      prev = e;
    end
  endtask

  task automatic test_early_release();
    logic [3:0] exp_g [7] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
    logic [3:0] req_v [7] = '{4'b0110, 4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    do_reset();
    bus.req = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++;
      if (bus.gnt !== exp_g[i]) begin
        failed++;
        $display("FAIL early_release cycle %0d gnt=%b expected %b", i + 1, bus.gnt, exp_g[i]);
      end
      bus.req = req_v[i];
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req = 4'b1000;
    tick();
    tick();
    tick();
    tests++;
    if (bus.gnt !== 4'b1000 || bus.ledr !== 16'h3333) begin
      failed++;
      $display("FAIL mid_reset_setup gnt=%b ledr=%h expected 1000/3333", bus.gnt, bus.ledr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({bus.gnt, bus.busy, bus.owner, bus.ledr} !== {4'b0000, 1'b0, 2'd0, 16'h0000}) begin
      failed++;
      $display("FAIL mid_reset_clear gnt=%b busy=%b owner=%0d ledr=%h expected 0000/0/0/0000",
               bus.gnt, bus.busy, bus.owner, bus.ledr);
    end
    tick();
    tests++;
    if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3) begin
      failed++;
      $display("FAIL mid_reset_regrant gnt=%b owner=%0d expected 1000/3", bus.gnt, bus.owner);
    end
  endtask

`ifdef LEDR_ARBITER_MANUAL_EN
  task automatic test_manual();
    logic [3:0]  exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic [15:0] exp_l [6] = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h1111, 16'h1111, 16'h1111};
    do_reset();
    bus.req = 4'b0011;
    tick();
    tick();
    d[2] = 16'h00FF;
    apply_data();
    man_sel = 2'd2;
    man_en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (bus.gnt !== exp_g[i] || bus.ledr !== exp_l[i]) begin
        failed++;
        $display("FAIL manual cycle %0d gnt=%b ledr=%h expected %b/%h",
                 i, bus.gnt, bus.ledr, exp_g[i], exp_l[i]);
      end
      if (i == 2) man_en = 1'b0;
    end
  endtask
`endif

  initial begin
    bus.req = 4'b0000;
    apply_data();
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_mid_reset();
`ifdef LEDR_ARBITER_MANUAL_EN
    test_manual();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
